// File: rtl/qspi_pkg.sv
// Shared types and default widths for the QSPI command front-end.
package qspi_pkg;

    localparam int unsigned QSPI_DATA_WIDTH    = 4;
    localparam int unsigned QSPI_ADDRESS_WIDTH = 32;
    localparam int unsigned QSPI_COMMAND_WIDTH = 8;
    localparam int unsigned QSPI_MODE_WIDTH    = 2;

    // Clock polarity: level of SCLK while idle.
    localparam logic [QSPI_MODE_WIDTH-1:0] CPOL_IDLE_LOW     = 2'd0;
    localparam logic [QSPI_MODE_WIDTH-1:0] CPOL_IDLE_HIGH    = 2'd1;
    // Clock phase: which SCLK edge samples data.
    localparam logic [QSPI_MODE_WIDTH-1:0] CPHA_SAMPLE_LEAD  = 2'd0;
    localparam logic [QSPI_MODE_WIDTH-1:0] CPHA_SAMPLE_TRAIL = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESP      = 2'd3
    } seq_state_t;

endpackage

// File: rtl/qspi_req_fifo.sv
// Request queue: synchronous FIFO, head visible combinationally, no read-through.
module qspi_req_fifo #(
    parameter int unsigned WIDTH = 46,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count < CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/qspi_cmd_sequencer.sv
// Queues host flash requests and issues them one at a time to the SPI controller.
module qspi_cmd_sequencer
    import qspi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = QSPI_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH  = QSPI_ADDRESS_WIDTH,
    parameter int unsigned COMMAND_WIDTH  = QSPI_COMMAND_WIDTH,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_req_valid,
    output logic                          o_req_ready,
    input  logic [COMMAND_WIDTH-1:0]      i_req_command,
    input  logic [ADDRESS_WIDTH-1:0]      i_req_address,
    input  logic [DATA_WIDTH-1:0]         i_req_data,
    input  logic [QSPI_MODE_WIDTH-1:0]    i_req_cpol,
    input  logic [QSPI_MODE_WIDTH-1:0]    i_req_cpha,
    output logic                          o_ctl_start,
    output logic [COMMAND_WIDTH-1:0]      o_ctl_command,
    output logic [ADDRESS_WIDTH-1:0]      o_ctl_address,
    output logic [DATA_WIDTH-1:0]         o_ctl_data_in,
    output logic [QSPI_MODE_WIDTH-1:0]    o_ctl_cpol,
    output logic [QSPI_MODE_WIDTH-1:0]    o_ctl_cpha,
    input  logic                          i_ctl_busy,
    input  logic                          i_ctl_done,
    input  logic [DATA_WIDTH-1:0]         i_ctl_data_out,
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic [DATA_WIDTH-1:0]         o_rsp_data,
    output logic                          o_rsp_error,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_idle
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TMR_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned ENTRY_W = COMMAND_WIDTH + ADDRESS_WIDTH + DATA_WIDTH
                                    + 2 * QSPI_MODE_WIDTH;

    seq_state_t                   r_state;
    logic [TMR_W-1:0]             r_timer;
    logic                         r_seen_busy;
    logic                         r_ctl_start;
    logic [COMMAND_WIDTH-1:0]     r_ctl_command;
    logic [ADDRESS_WIDTH-1:0]     r_ctl_address;
    logic [DATA_WIDTH-1:0]        r_ctl_data_in;
    logic [QSPI_MODE_WIDTH-1:0]   r_ctl_cpol;
    logic [QSPI_MODE_WIDTH-1:0]   r_ctl_cpha;
    logic                         r_rsp_valid;
    logic [DATA_WIDTH-1:0]        r_rsp_data;
    logic                         r_rsp_error;

    logic [ENTRY_W-1:0]           w_push_entry;
    logic [ENTRY_W-1:0]           w_head;
    logic [CNT_W-1:0]             w_count;
    logic                         w_push;
    logic                         w_pop;
    logic [COMMAND_WIDTH-1:0]     w_head_command;
    logic [ADDRESS_WIDTH-1:0]     w_head_address;
    logic [DATA_WIDTH-1:0]        w_head_data;
    logic [QSPI_MODE_WIDTH-1:0]   w_head_cpol;
    logic [QSPI_MODE_WIDTH-1:0]   w_head_cpha;

    assign w_push_entry = {i_req_command, i_req_address, i_req_data, i_req_cpol, i_req_cpha};
    assign {w_head_command, w_head_address, w_head_data, w_head_cpol, w_head_cpha} = w_head;

    assign o_req_ready = !i_reset && (w_count < CNT_W'(FIFO_DEPTH));
    assign w_push      = i_req_valid && o_req_ready;
    assign w_pop       = (r_state == ST_IDLE) && (w_count != '0);

    qspi_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    // Launch/wait/respond FSM with timeout; a done only counts after busy was seen.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_seen_busy   <= 1'b0;
            r_ctl_start   <= 1'b0;
            r_ctl_command <= '0;
            r_ctl_address <= '0;
            r_ctl_data_in <= '0;
            r_ctl_cpol    <= '0;
            r_ctl_cpha    <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_error   <= 1'b0;
        end else begin
            r_ctl_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_count != '0) begin
                        r_ctl_command <= w_head_command;
                        r_ctl_address <= w_head_address;
                        r_ctl_data_in <= w_head_data;
                        r_ctl_cpol    <= w_head_cpol;
                        r_ctl_cpha    <= w_head_cpha;
                        r_seen_busy   <= 1'b0;
                        r_timer       <= '0;
                        r_ctl_start   <= 1'b1;
                        r_state       <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (i_ctl_busy) begin
                        r_seen_busy <= 1'b1;
                    end
                    if (i_ctl_done && r_seen_busy) begin
                        r_rsp_data  <= i_ctl_data_out;
                        r_rsp_error <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        r_rsp_data  <= '0;
                        r_rsp_error <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ctl_start   = r_ctl_start;
    assign o_ctl_command = r_ctl_command;
    assign o_ctl_address = r_ctl_address;
    assign o_ctl_data_in = r_ctl_data_in;
    assign o_ctl_cpol    = r_ctl_cpol;
    assign o_ctl_cpha    = r_ctl_cpha;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_data    = r_rsp_data;
    assign o_rsp_error   = r_rsp_error;
    assign o_fifo_count  = w_count;
    assign o_idle        = (r_state == ST_IDLE) && (w_count == '0);

endmodule

// File: doc/qspi_cmd_sequencer.md
# qspi_cmd_sequencer

Upstream front-end for `qspi_spi_controller`. Accepts flash transaction requests (command, address, write nibble, CPOL/CPHA) from the host over a valid/ready port and buffers them in a small FIFO. Issues them one at a time to the controller via a single-cycle `start` pulse, then waits for completion with a timeout. Returns the controller's `data_out` (or an error) on a valid/ready response port.

## Interface
- `DATA_WIDTH`, 4: controller data width.
- `ADDRESS_WIDTH`, 32: flash address width.
- `COMMAND_WIDTH`, 8: opcode width.
- `FIFO_DEPTH`, 4: request queue depth; power of 2, ≥2.
- `TIMEOUT_CYCLES`, 1024: max cycles in WAIT_DONE before error.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: host request valid.
- `req_ready` out 1: high when the queue has space.
- `req_command` in COMMAND_WIDTH: opcode.
- `req_address` in ADDRESS_WIDTH: flash address.
- `req_data` in DATA_WIDTH: write data.
- `req_cpol`, `req_cpha` in 2 each: clock mode for this transaction.
- `ctl_start` out 1: one-cycle start pulse to the controller.
- `ctl_command`, `ctl_address`, `ctl_data_in`, `ctl_cpol`, `ctl_cpha` out: registered request fields, held stable from launch through response.
- `ctl_busy` in 1, `ctl_done` in 1, `ctl_data_out` in DATA_WIDTH: controller status and read data.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_data` out DATA_WIDTH: captured `ctl_data_out`.
- `rsp_error` out 1: 1 = timeout.
- `fifo_count` out clog2(FIFO_DEPTH)+1: queued requests.
- `idle` out 1: FSM in IDLE and FIFO empty.

## Operation
- Push on `req_valid && req_ready`; `req_ready = !reset && fifo_count < FIFO_DEPTH`. No bypass: a full queue never accepts.
- Simultaneous push and pop leaves `fifo_count` unchanged.
- FSM states: IDLE, LAUNCH, WAIT_DONE, RESP.
- IDLE: if `fifo_count != 0`, pop the head, load all `ctl_*` field registers, clear `seen_busy` and the timer, go to LAUNCH.
- LAUNCH: `ctl_start=1` for exactly this cycle, then go to WAIT_DONE.
- WAIT_DONE: set `seen_busy` on `ctl_busy`. If `ctl_done && seen_busy` → capture `rsp_data = ctl_data_out`, `rsp_error=0`, go to RESP. Otherwise increment the timer; at `timer == TIMEOUT_CYCLES-1` → `rsp_data=0`, `rsp_error=1`, go to RESP.
- Done and timeout in the same cycle: done wins.
- `ctl_done` is ignored outside WAIT_DONE, and also before busy is seen, so a stale done from the previous transaction is rejected.
- RESP: `rsp_valid=1` with data and error held until `rsp_ready`; then go to IDLE. No new launch while a response is pending.
- Responses return in request order; exactly one response per accepted request.

## Timing
- Reset values: state IDLE, FIFO empty, `ctl_start=0`, all `ctl_*` fields 0, `rsp_valid=0`, `rsp_data=0`, `rsp_error=0`, `fifo_count=0`, `idle=1`, `req_ready=0` while `reset` is high.
- Request accepted at edge k with an idle FSM: `ctl_start` is high in cycle k+1→k+2.
- Done qualified at edge d: `rsp_valid` is high from edge d.
- RESP exits on the `rsp_ready` edge. If the FIFO is non-empty, the next `ctl_start` follows 2 cycles later (IDLE, then LAUNCH).
- Reset asserted mid-transaction: abort next edge; queue flushed, no response issued, `ctl_start` low. The controller is reset by its own reset.

## Structure
- Shared package `qspi_pkg`:
  - FSM state enum;
  - default width constants (4/32/8);
  - CPOL/CPHA encodings.
- Sub-module `qspi_req_fifo`: synchronous FIFO with parameterised width and depth, push/pop/count, and no read-through. The entry packs command, address, data, cpol and cpha.
- The sequencer contains the FSM, timer, `seen_busy` flag and output registers.

## Test plan
- Single request: cmd 0x5A, addr 0xA0A0A0A0, data 0x3, CPOL=0, CPHA=0. Model busy for 20 cycles, then done with data_out 0x3 → one `ctl_start` pulse 1 cycle after accept; `rsp_data=0x3`, `rsp_error=0`.
- Fill queue: push 5 requests back-to-back with the controller busy → `req_ready` drops after 4; `fifo_count=4`. Responses arrive in order for all 4 CPOL/CPHA combinations, and `ctl_cpol`/`ctl_cpha` match each request.
- Timeout: controller never responds → `rsp_error=1` and `rsp_data=0` exactly `TIMEOUT_CYCLES` cycles after entering WAIT_DONE.
- Stale done: `ctl_done` held high from the previous transaction through LAUNCH → not accepted until busy is seen, then a fresh done completes.
- Response backpressure: `rsp_ready=0` for 10 cycles → `rsp_valid` and data stay stable, and no new `ctl_start` is issued.
- Reset mid-WAIT_DONE with 2 requests queued → next cycle: `fifo_count=0`, `idle=1`, no `rsp_valid`.
